// File: rtl/led_scanner.sv
// led_scanner: 8-LED bouncing scanner whose trail fades by PWM, one brightness per LED.
module led_scanner #(
  parameter int   TICK_DIV    = 2400000,
  parameter int   PWM_BITS    = 8,
  parameter int   DECAY_SHIFT = 1,
  parameter logic LED_ON      = 1'b0
) (
  input  logic       CLK_48,
  input  logic       reset,
  input  logic       enable,
  output logic [7:0] leds,
  output logic [2:0] position,
  output logic       step
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  localparam logic [PWM_BITS-1:0] MAX = '1;
  typedef enum logic {UP, DOWN} dir_t;
  dir_t dir, dir_d;
  logic [PW-1:0] presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [7:0][PWM_BITS-1:0] bright, bright_d;
  logic [2:0] pos_d;
  logic [7:0] lit;
  logic step_req;
  assign step_req = enable && presc == LAST;
  always_comb begin
    dir_d = dir;
    pos_d = position;
    bright_d = bright;
    if (step_req) begin
      if (dir == UP) begin
        dir_d = (position == 3'd7) ? DOWN : UP;
        pos_d = (position == 3'd7) ? 3'd6 : position + 3'd1;
      end else begin
        dir_d = (position == 3'd0) ? UP : DOWN;
        pos_d = (position == 3'd0) ? 3'd1 : position - 3'd1;
      end
      // the freshly reached head is set to full, overriding its own decay
      for (int i = 0; i < 8; i++)
        bright_d[i] = (3'(i) == pos_d) ? MAX : bright[i] >> DECAY_SHIFT;
    end
  end
  always_comb begin
    lit = '0;
    for (int i = 0; i < 8; i++)
      lit[i] = bright[i] > pwm_cnt;
  end
  always_ff @(posedge CLK_48) begin
    if (reset) begin
      presc <= '0;
      pwm_cnt <= '0;
      position <= '0;
      dir <= UP;
      step <= 1'b0;
      bright <= '0;
      bright[0] <= MAX;
      leds <= {8{~LED_ON}};
    end else begin
      if (enable)
        presc <= step_req ? '0 : presc + 1'b1;
      pwm_cnt <= pwm_cnt + 1'b1;
      step <= step_req;
      dir <= dir_d;
      position <= pos_d;
      bright <= bright_d;
      leds <= lit ^ {8{~LED_ON}};
    end
  end
endmodule
